// File: rtl/digit_scan_mux.sv
// Eight-digit seven-segment scan driver: one-cold active-low anodes, per-slot blanking, per-frame input snapshot.
// Optional digit blinking is enabled by defining DISP_BLINK_EN.
module digit_scan_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 62
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits_in,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  blink_mask,
  output logic [3:0]  digit_out,
  output logic [7:0]  an,
  output logic [2:0]  digit_idx,
  output logic        frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   dig_q, dig_d;
  logic [7:0]    en_q, en_d;
  state_t        state_q, state_d;
  logic [7:0]    an_q, an_d;
  logic [3:0]    dout_q, dout_d;
  logic          fs_q, fs_d;
  logic          load, new_frame, show;

`ifdef DISP_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [7:0]    bmask_q, bmask_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, 8'(BLINK_FRAMES)};
`endif

  always_comb begin
    run_d     = 1'b1;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dig_d     = dig_q;
    en_d      = en_q;
    load      = 1'b0;
    // run_q low means the first edge after reset: start slot 0 on live inputs
    if (!run_q) begin
      cnt_d = '0;
      idx_d = '0;
      load  = 1'b1;
    end else if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
      load  = (idx_q == 3'd7);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (load) begin
      dig_d = digits_in;
      en_d  = digit_en;
    end
    new_frame = run_q & load;
    fs_d      = (idx_d == 3'd0) && (cnt_d == '0);
    state_d   = (cnt_d < CW'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;
    show      = en_d[idx_d];
`ifdef DISP_BLINK_EN
    bmask_d = load ? blink_mask : bmask_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (new_frame) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    show = show & (phase_d | ~bmask_d[idx_d]);
`else
    show = show | (new_frame & 1'b0);
`endif
    an_d   = (state_d == ST_DRIVE && show) ? ~(8'b1 << idx_d) : 8'hFF;
    dout_d = dig_d[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      en_q    <= '0;
      state_q <= ST_BLANK;
      an_q    <= 8'hFF;
      dout_q  <= 4'h0;
      fs_q    <= 1'b0;
`ifdef DISP_BLINK_EN
      bmask_q <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b1;
`endif
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      en_q    <= en_d;
      state_q <= state_d;
      an_q    <= an_d;
      dout_q  <= dout_d;
      fs_q    <= fs_d;
`ifdef DISP_BLINK_EN
      bmask_q <= bmask_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
`endif
    end
  end

  assign an          = an_q;
  assign digit_out   = dout_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;

endmodule
